// File: rtl/program_memory.sv
// Byte-wide program memory with a serial load FSM and big-endian word reads.
// Define IMEM_ALIGN_CHECK_EN to reject misaligned read addresses.
module program_memory #(
    parameter int MEMORY_WIDTH   = 8,
    parameter int MEMORY_DEPTH   = 64,
    parameter int NB_ADDR        = 32,
    parameter int NB_INSTRUCTION = 32
) (
    input  logic                            i_clock,
    input  logic                            i_reset,
    input  logic                            i_read_enable,
    input  logic [NB_ADDR-1:0]              i_read_addr,
    output logic [NB_INSTRUCTION-1:0]       o_read_data,
    output logic                            o_read_error,
    input  logic                            i_load_start,
    input  logic                            i_load_valid,
    input  logic [MEMORY_WIDTH-1:0]         i_load_byte,
    input  logic                            i_load_end,
    output logic                            o_load_ready,
    output logic                            o_load_done,
    output logic [$clog2(MEMORY_DEPTH):0]   o_load_count
);

    localparam int AW = $clog2(MEMORY_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [CW-1:0]             r_count;
    logic [CW-1:0]             w_count_next;
    logic                      w_mem_we;
    logic [MEMORY_WIDTH-1:0]   r_mem [MEMORY_DEPTH];
    logic [NB_INSTRUCTION-1:0] r_read_data;
    logic                      r_read_error;

    logic [NB_ADDR-1:0]        w_addr;
    logic                      w_misaligned;
    logic                      w_range_err;
    logic [AW-1:0]             w_idx;
    logic [NB_INSTRUCTION-1:0] w_word;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_mem_we     = 1'b0;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (i_load_start) begin
                    w_state_next = S_LOAD;
                    w_count_next = '0;
                end
            end
            S_LOAD: begin
                // A restart wins over any byte offered in the same cycle.
                if (i_load_start) begin
                    w_count_next = '0;
                end else begin
                    if (i_load_valid) begin
                        w_mem_we     = 1'b1;
                        w_count_next = r_count + CW'(1);
                        if (r_count == CW'(MEMORY_DEPTH - 1)) begin
                            w_state_next = S_DONE;
                        end
                    end
                    if (i_load_end) begin
                        w_state_next = S_DONE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Storage has no reset so a program survives a reset.
    always_ff @(posedge i_clock) begin
        if (w_mem_we && !i_reset) begin
            r_mem[r_count[AW-1:0]] <= i_load_byte;
        end
    end

`ifdef IMEM_ALIGN_CHECK_EN
    assign w_addr       = i_read_addr;
    assign w_misaligned = |i_read_addr[1:0];
`else
    assign w_addr       = i_read_addr & ~NB_ADDR'(3);
    assign w_misaligned = 1'b0;
`endif

    assign w_range_err = (w_addr > NB_ADDR'(MEMORY_DEPTH - 4));
    assign w_idx       = w_addr[AW-1:0];
    assign w_word      = {r_mem[w_idx],
                          r_mem[w_idx + AW'(1)],
                          r_mem[w_idx + AW'(2)],
                          r_mem[w_idx + AW'(3)]};

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_read_data  <= '0;
            r_read_error <= 1'b0;
        end else if (i_read_enable && r_state != S_LOAD) begin
            if (w_range_err || w_misaligned) begin
                r_read_data  <= '0;
                r_read_error <= 1'b1;
            end else begin
                r_read_data  <= w_word;
                r_read_error <= 1'b0;
            end
        end
    end

    assign o_read_data  = r_read_data;
    assign o_read_error = r_read_error;
    assign o_load_ready = (r_state == S_LOAD);
    assign o_load_done  = (r_state == S_DONE);
    assign o_load_count = r_count;

endmodule

// File: tb/tb_program_memory.sv
// Directed self-checking bench for program_memory (default parameters).
module tb_program_memory;

    logic        clk = 1'b0;
    logic        rst;
    logic        ren;
    logic [31:0] raddr;
    logic [31:0] rdata;
    logic        rerr;
    logic        lstart;
    logic        lvalid;
    logic [7:0]  lbyte;
    logic        lend;
    logic        lready;
    logic        ldone;
    logic [6:0]  lcount;

    int checks   = 0;
    int failures = 0;

    program_memory dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_read_enable (ren),
        .i_read_addr   (raddr),
        .o_read_data   (rdata),
        .o_read_error  (rerr),
        .i_load_start  (lstart),
        .i_load_valid  (lvalid),
        .i_load_byte   (lbyte),
        .i_load_end    (lend),
        .o_load_ready  (lready),
        .o_load_done   (ldone),
        .o_load_count  (lcount)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [31:0] a);
        ren   = 1'b1;
        raddr = a;
        tick();
        ren   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ren = 1'b0; raddr = '0;
        lstart = 1'b0; lvalid = 1'b0; lbyte = '0; lend = 1'b0;
        tick();
        tick();
        chk("rst_ready", {31'd0, lready}, 32'd0);
        chk("rst_done", {31'd0, ldone}, 32'd0);
        chk("rst_count", {25'd0, lcount}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rerr", {31'd0, rerr}, 32'd0);

        // Full 64-byte load of 0x00..0x3F
        rst = 1'b0;
        lstart = 1'b1;
        tick();
        lstart = 1'b0;
        chk("start_ready", {31'd0, lready}, 32'd1);
        chk("start_count", {25'd0, lcount}, 32'd0);
        for (int i = 0; i < 64; i++) begin
            lvalid = 1'b1;
            lbyte  = 8'(i);
            tick();
            if (i == 62) begin
                chk("cnt63", {25'd0, lcount}, 32'd63);
                chk("rdy63", {31'd0, lready}, 32'd1);
            end
        end
        lvalid = 1'b0;
        chk("full_done", {31'd0, ldone}, 32'd1);
        chk("full_count", {25'd0, lcount}, 32'd64);
        chk("full_ready", {31'd0, lready}, 32'd0);

        // Bytes outside LOAD are ignored
        lvalid = 1'b1; lbyte = 8'hFF; lend = 1'b1;
        tick();
        lvalid = 1'b0; lend = 1'b0;
        chk("done_ign_cnt", {25'd0, lcount}, 32'd64);
        chk("done_ign_st", {31'd0, ldone}, 32'd1);

        rd(32'd0);
        chk("rd0", rdata, 32'h00010203);
        chk("rd0_err", {31'd0, rerr}, 32'd0);
        rd(32'd4);
        chk("rd4", rdata, 32'h04050607);
        rd(32'd8);
        chk("rd8", rdata, 32'h08090A0B);
        rd(32'd12);
        chk("rd12", rdata, 32'h0C0D0E0F);
        rd(32'd60);
        chk("rd60", rdata, 32'h3C3D3E3F);
        chk("rd60_err", {31'd0, rerr}, 32'd0);
        rd(32'd64);
        chk("rd64", rdata, 32'd0);
        chk("rd64_err", {31'd0, rerr}, 32'd1);
        raddr = 32'd0;
        tick();
        chk("hold_data", rdata, 32'd0);
        chk("hold_err", {31'd0, rerr}, 32'd1);
        rd(32'd0);
        chk("rd0b", rdata, 32'h00010203);

        // Short load ended by i_load_end; reads ignored while loading
        lstart = 1'b1;
        tick();
        lstart = 1'b0;
        for (int i = 0; i < 8; i++) begin
            lvalid = 1'b1;
            lbyte  = 8'hAA;
            ren    = (i == 3);
            raddr  = 32'd64;
            tick();
        end
        ren = 1'b0;
        chk("load_rd_data", rdata, 32'h00010203);
        chk("load_rd_err", {31'd0, rerr}, 32'd0);
        lbyte = 8'hBB; lend = 1'b1;
        tick();
        lvalid = 1'b0; lend = 1'b0;
        chk("end_done", {31'd0, ldone}, 32'd1);
        chk("end_count", {25'd0, lcount}, 32'd9);
        rd(32'd8);
        chk("rd8_end", rdata, 32'hBB090A0B);
        rd(32'd0);
        chk("rd0_aa", rdata, 32'hAAAAAAAA);

        // Misaligned reads
        rd(32'd6);
`ifdef IMEM_ALIGN_CHECK_EN
        chk("rd6", rdata, 32'd0);
        chk("rd6_err", {31'd0, rerr}, 32'd1);
`else
        chk("rd6", rdata, 32'hAAAAAAAA);
        chk("rd6_err", {31'd0, rerr}, 32'd0);
`endif
        rd(32'd61);
`ifdef IMEM_ALIGN_CHECK_EN
        chk("rd61", rdata, 32'd0);
        chk("rd61_err", {31'd0, rerr}, 32'd1);
`else
        chk("rd61", rdata, 32'h3C3D3E3F);
        chk("rd61_err", {31'd0, rerr}, 32'd0);
`endif

        // Restart mid-load, then reset mid-load
        lstart = 1'b1;
        tick();
        lstart = 1'b0;
        lvalid = 1'b1; lbyte = 8'h11;
        tick();
        chk("pre_restart", {25'd0, lcount}, 32'd1);
        lstart = 1'b1; lbyte = 8'h22;
        tick();
        lstart = 1'b0;
        chk("restart_cnt", {25'd0, lcount}, 32'd0);
        chk("restart_rdy", {31'd0, lready}, 32'd1);
        lbyte = 8'h33; tick();
        lbyte = 8'h44; tick();
        lbyte = 8'h55; tick();
        chk("three_cnt", {25'd0, lcount}, 32'd3);
        rst = 1'b1; lbyte = 8'h66; lstart = 1'b1; ren = 1'b1;
        tick();
        rst = 1'b0; lvalid = 1'b0; lstart = 1'b0; ren = 1'b0;
        chk("mid_rst_cnt", {25'd0, lcount}, 32'd0);
        chk("mid_rst_rdy", {31'd0, lready}, 32'd0);
        chk("mid_rst_done", {31'd0, ldone}, 32'd0);
        chk("mid_rst_rdata", rdata, 32'd0);
        rd(32'd0);
        chk("rd0_after_rst", rdata, 32'h334455AA);
        chk("rd0_after_err", {31'd0, rerr}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
